mod_cascade_counter: RTL and testbench

Two-digit synchronous cascaded modulo counter with parametrised digit moduli, giving a total modulus of LO_MOD*HI_MOD. Both digits share one clock: the high digit advances on the low digit's carry enable instead of a carry-derived clock, so the composite count and terminal flags are glitch-free. It adds enable, synchronous clear, parallel load with range check, and an optional down-count mode. It serves as the standard frame/slot counter for timing generators in the design.

---
 rtl/mod_cnt_pkg.sv | 32 +++
 rtl/mod_digit.sv | 86 ++++++++
 rtl/mod_cascade_counter.sv | 139 +++++++++++++
 tb/tb_mod_cascade_counter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_cnt_pkg
// Description : Shared types and helpers for the cascaded modulo counter.
//               - clog2_min1 : register width for a modulus, never below 1
//               - cnt_dir_e  : count direction (CNT_UP / CNT_DOWN)
//               - dig_cmd_e  : per-digit command (hold, step, clear, load)
// Revision    : 1.0 - initial release
// ============================================================================
package mod_cnt_pkg;

    // A modulus of 1 would otherwise give a zero-width register.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_dir_e;

    typedef enum logic [1:0] {
        DIG_HOLD  = 2'd0,
        DIG_STEP  = 2'd1,
        DIG_CLEAR = 2'd2,
        DIG_LOAD  = 2'd3
    } dig_cmd_e;

endpackage : mod_cnt_pkg
`default_nettype wire

// File: rtl/mod_digit.sv
`default_nettype none
// ============================================================================
// Module      : mod_digit
// Description : One modulo-MOD digit of the cascaded counter. A step command
//               only advances the digit when its carry-in enable is high, so
//               every digit shares the single clock.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               cmd [1:0]      - dig_cmd_e command (hold/step/clear/load)
//               dir            - 0 up, 1 down (only with MOD_CNT_DOWN_EN)
//               load_val [W-1:0] - value taken on a load command
//               cin            - carry-in enable for a step
//               val [W-1:0]    - digit value, always 0..MOD-1
//               cout           - digit is at its terminal and stepping
// Config      : MOD_CNT_DOWN_EN adds the dir port and the borrow logic.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_digit
    import mod_cnt_pkg::*;
#(
    parameter  int MOD = 4,
    localparam int W   = clog2_min1(MOD)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   cmd,
`ifdef MOD_CNT_DOWN_EN
    input  logic         dir,
`endif
    input  logic [W-1:0] load_val,
    input  logic         cin,
    output logic [W-1:0] val,
    output logic         cout
);

    localparam logic [W-1:0] c_max = W'(MOD - 1);

    dig_cmd_e     w_cmd;
    logic         w_step;
    logic         w_at_term;
    logic [W-1:0] w_next;
    logic [W-1:0] r_val;

    assign w_cmd  = dig_cmd_e'(cmd);
    assign w_step = (w_cmd == DIG_STEP) && cin;

`ifdef MOD_CNT_DOWN_EN
    cnt_dir_e w_dir;
    assign w_dir     = cnt_dir_e'(dir);
    // Terminal is the top value counting up and zero counting down.
    assign w_at_term = (w_dir == CNT_DOWN) ? (r_val == '0) : (r_val == c_max);

    always_comb begin
        w_next = r_val;
        if (w_dir == CNT_DOWN) begin
            w_next = w_at_term ? c_max : (r_val - 1'b1);
        end else begin
            w_next = w_at_term ? '0 : (r_val + 1'b1);
        end
    end
`else
    assign w_at_term = (r_val == c_max);

    always_comb begin
        w_next = w_at_term ? '0 : (r_val + 1'b1);
    end
`endif

    assign cout = w_step && w_at_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= '0;
        end else begin
            case (w_cmd)
                DIG_CLEAR: r_val <= '0;
                DIG_LOAD:  r_val <= load_val;
                DIG_STEP:  if (cin) r_val <= w_next;
                default:   r_val <= r_val;
            endcase
        end
    end

    assign val = r_val;

endmodule : mod_digit
`default_nettype wire

// File: rtl/mod_cascade_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_cascade_counter
// Description : Two-digit synchronous cascaded modulo counter, total modulus
//               LO_MOD*HI_MOD. The high digit steps on the low digit's carry
//               enable, not on a derived clock, so all outputs are glitch-free.
//               Priority per cycle: clr > load > en > hold.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               en               - count enable
//               clr              - synchronous clear to 0
//               load, load_val   - synchronous composite load (range checked)
//               dir              - 0 up, 1 down (only with MOD_CNT_DOWN_EN)
//               lo, hi           - digit values
//               q                - composite count hi*LO_MOD + lo
//               tc               - terminal count (q==MOD-1 up, q==0 down)
//               wrap             - one-cycle pulse after a wrapping step
//               load_err         - one-cycle pulse after a rejected load
// Config      : MOD_CNT_DOWN_EN adds dir and down counting; undefined gives
//               an up-only counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_cascade_counter
    import mod_cnt_pkg::*;
#(
    parameter  int LO_MOD = 4,
    parameter  int HI_MOD = 5,
    localparam int MOD    = LO_MOD * HI_MOD,
    localparam int LO_W   = clog2_min1(LO_MOD),
    localparam int HI_W   = clog2_min1(HI_MOD),
    localparam int Q_W    = clog2_min1(MOD)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    input  logic            load,
    input  logic [Q_W-1:0]  load_val,
`ifdef MOD_CNT_DOWN_EN
    input  logic            dir,
`endif
    output logic [LO_W-1:0] lo,
    output logic [HI_W-1:0] hi,
    output logic [Q_W-1:0]  q,
    output logic            tc,
    output logic            wrap,
    output logic            load_err
);

    localparam logic [Q_W-1:0] c_lo_mod_q = Q_W'(LO_MOD);
    localparam logic [Q_W-1:0] c_mod_m1   = Q_W'(MOD - 1);
    // One extra bit so a power-of-two MOD does not fold to zero.
    localparam logic [Q_W:0]   c_mod_x    = (Q_W + 1)'(MOD);

    dig_cmd_e        w_cmd;
    logic            w_load_ok;
    logic [LO_W-1:0] w_lo_load;
    logic [HI_W-1:0] w_hi_load;
    logic [LO_W-1:0] w_lo;
    logic [HI_W-1:0] w_hi;
    logic            w_lo_cout;
    logic            w_hi_cout;
    logic [Q_W-1:0]  w_q;
    logic            r_wrap;
    logic            r_load_err;

    assign w_load_ok = ({1'b0, load_val} < c_mod_x);
    assign w_lo_load = LO_W'(load_val % c_lo_mod_q);
    assign w_hi_load = HI_W'(load_val / c_lo_mod_q);

    // A rejected load degrades to hold so both digits keep their value.
    always_comb begin
        w_cmd = DIG_HOLD;
        if (clr) begin
            w_cmd = DIG_CLEAR;
        end else if (load) begin
            w_cmd = w_load_ok ? DIG_LOAD : DIG_HOLD;
        end else if (en) begin
            w_cmd = DIG_STEP;
        end
    end

    mod_digit #(
        .MOD      (LO_MOD)
    ) u_lo (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (w_cmd),
`ifdef MOD_CNT_DOWN_EN
        .dir      (dir),
`endif
        .load_val (w_lo_load),
        .cin      (1'b1),
        .val      (w_lo),
        .cout     (w_lo_cout)
    );

    mod_digit #(
        .MOD      (HI_MOD)
    ) u_hi (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (w_cmd),
`ifdef MOD_CNT_DOWN_EN
        .dir      (dir),
`endif
        .load_val (w_hi_load),
        .cin      (w_lo_cout),
        .val      (w_hi),
        .cout     (w_hi_cout)
    );

    assign w_q = (Q_W'(w_hi) * c_lo_mod_q) + Q_W'(w_lo);

`ifdef MOD_CNT_DOWN_EN
    assign tc = (cnt_dir_e'(dir) == CNT_DOWN) ? (w_q == '0) : (w_q == c_mod_m1);
`else
    assign tc = (w_q == c_mod_m1);
`endif

    // The high digit's carry-out is exactly "enabled step while tc" with no
    // clr or load, since the step command already encodes that priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= w_hi_cout;
            r_load_err <= !clr && load && !w_load_ok;
        end
    end

    assign lo       = w_lo;
    assign hi       = w_hi;
    assign q        = w_q;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule : mod_cascade_counter
`default_nettype wire

// File: tb/tb_mod_cascade_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_cascade_counter
// Description : Scoreboard bench for mod_cascade_counter. Two instances run
//               from the same stimulus: defaults (4 x 5) and odd moduli
//               (3 x 7). The reference model keeps one integer count per
//               instance and derives digits and flags arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_cascade_counter;

    localparam int Q_W = 5;

    typedef struct {
        int q;
        int lo;
        int hi;
        int tc;
        int wrap;
        int lerr;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           clr;
    logic           load;
    logic           dir;
    logic [Q_W-1:0] load_val;

    logic [1:0]     lo0, lo1;
    logic [2:0]     hi0, hi1;
    logic [Q_W-1:0] q0, q1;
    logic           tc0, tc1, wrap0, wrap1, le0, le1;

    int   errors = 0;
    int   checks = 0;
    int   lmv[2] = '{4, 3};
    int   hmv[2] = '{5, 7};
    int   mq[2]  = '{0, 0};
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t ex0, ex1;

    always #5 clk = ~clk;

    mod_cascade_counter #(.LO_MOD(4), .HI_MOD(5)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
`ifdef MOD_CNT_DOWN_EN
        .dir      (dir),
`endif
        .lo       (lo0),
        .hi       (hi0),
        .q        (q0),
        .tc       (tc0),
        .wrap     (wrap0),
        .load_err (le0)
    );

    mod_cascade_counter #(.LO_MOD(3), .HI_MOD(7)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
`ifdef MOD_CNT_DOWN_EN
        .dir      (dir),
`endif
        .lo       (lo1),
        .hi       (hi1),
        .q        (q1),
        .tc       (tc1),
        .wrap     (wrap1),
        .load_err (le1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a single count in 0..MOD-1 stepped with modular arithmetic.
    function automatic exp_t model_step(input int k, input bit e, input bit c,
                                        input bit l, input int lv, input bit d);
        int   m;
        exp_t x;
        m      = lmv[k] * hmv[k];
        x.wrap = 0;
        x.lerr = 0;
        if (c) begin
            mq[k] = 0;
        end else if (l) begin
            if (lv < m) mq[k] = lv;
            else        x.lerr = 1;
        end else if (e) begin
            if (d) begin
                x.wrap = (mq[k] == 0) ? 1 : 0;
                mq[k]  = (mq[k] + m - 1) % m;
            end else begin
                x.wrap = (mq[k] == m - 1) ? 1 : 0;
                mq[k]  = (mq[k] + 1) % m;
            end
        end
        x.q  = mq[k];
        x.lo = mq[k] % lmv[k];
        x.hi = mq[k] / lmv[k];
        x.tc = d ? ((mq[k] == 0) ? 1 : 0) : ((mq[k] == m - 1) ? 1 : 0);
        return x;
    endfunction

    task automatic cyc(input bit e, input bit c, input bit l, input int lv, input bit d);
        @(negedge clk);
        #1;
        en       = e;
        clr      = c;
        load     = l;
        load_val = lv[Q_W-1:0];
        dir      = d;
        sb0.push_back(model_step(0, e, c, l, lv, d));
        sb1.push_back(model_step(1, e, c, l, lv, d));
    endtask

    // Monitor: the counter presents a result every cycle; compare at negedge.
    always @(negedge clk) begin
        if (sb0.size() > 0) begin
            ex0 = sb0.pop_front();
            chk("d0_q",    int'(q0),    ex0.q);
            chk("d0_lo",   int'(lo0),   ex0.lo);
            chk("d0_hi",   int'(hi0),   ex0.hi);
            chk("d0_tc",   int'(tc0),   ex0.tc);
            chk("d0_wrap", int'(wrap0), ex0.wrap);
            chk("d0_lerr", int'(le0),   ex0.lerr);
        end
        if (sb1.size() > 0) begin
            ex1 = sb1.pop_front();
            chk("d1_q",    int'(q1),    ex1.q);
            chk("d1_lo",   int'(lo1),   ex1.lo);
            chk("d1_hi",   int'(hi1),   ex1.hi);
            chk("d1_tc",   int'(tc1),   ex1.tc);
            chk("d1_wrap", int'(wrap1), ex1.wrap);
            chk("d1_lerr", int'(le1),   ex1.lerr);
            chk("d1_range", (int'(q1) <= 20) ? 1 : 0, 1);
        end
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        dir      = 1'b0;
        load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q",    int'(q0),    0);
        chk("rst_lo",   int'(lo0),   0);
        chk("rst_hi",   int'(hi0),   0);
        chk("rst_tc",   int'(tc0),   0);
        chk("rst_wrap", int'(wrap0), 0);
        chk("rst_lerr", int'(le0),   0);
        chk("rst_q1",   int'(q1),    0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Free run: 45 steps covers two full wraps plus a partial lap.
        for (int i = 0; i < 45; i++) cyc(1, 0, 0, 0, 0);

        // Loads and clear priority.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 17, 0);
        cyc(0, 0, 1, 20, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 5, 0);
        cyc(0, 0, 1, 31, 0);

        // Enable gating across a wrap.
        cyc(0, 0, 1, 18, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Long run so the odd-moduli instance wraps several times.
        for (int i = 0; i < 50; i++) cyc(1, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            int r;
            int lv;
            bit e, c, l, d;
            r  = int'($urandom_range(0, 99));
            c  = (r < 3);
            l  = (r >= 3) && (r < 11);
            e  = ($urandom_range(0, 3) != 0);
            lv = int'($urandom_range(0, 31));
            d  = 1'b0;
`ifdef MOD_CNT_DOWN_EN
            d  = ($urandom_range(0, 1) != 0);
`endif
            cyc(e, c, l, lv, d);
        end

`ifdef MOD_CNT_DOWN_EN
        // Down through zero, then flip direction at the top value.
        cyc(0, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        #1;
        chk("dir_switch_tc", int'(tc0), 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
`endif

        // Asynchronous reset between edges at q = 13.
        cyc(0, 0, 1, 13, 0);
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk("pre_rst_q", int'(q0), 13);
        rst_n = 1'b0;
        #1;
        chk("async_rst_q",    int'(q0),    0);
        chk("async_rst_wrap", int'(wrap0), 0);
        chk("async_rst_lerr", int'(le0),   0);
        chk("async_rst_q1",   int'(q1),    0);
        mq[0] = 0;
        mq[1] = 0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb0.size() + sb1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mod_cascade_counter
`default_nettype wire
